// File: rtl/pipe_ctrl_if.sv
// ============================================================================
// Module  : pipe_ctrl_if
// Brief   : Handshake bundle between execute stage, bus, debug and pipe_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipe_ctrl_if;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_ex_i;
  logic        hold_bus_i;
  logic        halt_req_i;
  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic        flush_o;
  logic        hold_pc_o;
  logic        hold_if_o;
  logic        hold_ex_o;
  logic        halted_o;
  logic        timeout_o;

  modport slave (
    input  jump_en_i, jump_addr_i, hold_ex_i, hold_bus_i, halt_req_i,
    output jump_en_o, jump_addr_o, flush_o, hold_pc_o, hold_if_o, hold_ex_o,
           halted_o, timeout_o
  );

  modport master (
    output jump_en_i, jump_addr_i, hold_ex_i, hold_bus_i, halt_req_i,
    input  jump_en_o, jump_addr_o, flush_o, hold_pc_o, hold_if_o, hold_ex_o,
           halted_o, timeout_o
  );
endinterface

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module  : pipe_ctrl
// Brief   : Hold arbitration, redirect forwarding/deferral, flush and bus watchdog.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int HOLD_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  ctrl
);

  localparam logic [1:0]  ST_RUN       = 2'd0;
  localparam logic [1:0]  ST_JUMP_PEND = 2'd1;
  localparam logic [1:0]  ST_HALT      = 2'd2;
  localparam logic [2:0]  FLUSH_INIT   = 3'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LIM  = 16'(HOLD_TIMEOUT);
  localparam bit          WDOG_EN      = (HOLD_TIMEOUT != 0);

  logic [1:0]  state_q, state_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] wdog_q, wdog_d;
  logic        timeout_q, timeout_d;

  logic        halt_w;
  logic        any_hold_w;
  logic        redirect_w;
  logic [31:0] redirect_addr_w;

  always_comb begin
    halt_w          = (state_q == ST_HALT);
    any_hold_w      = ctrl.hold_ex_i | ctrl.hold_bus_i | halt_w;
    redirect_w      = 1'b0;
    redirect_addr_w = ctrl.jump_addr_i;
    state_d         = state_q;
    addr_d          = addr_q;

    case (state_q)
      ST_RUN: begin
        if (ctrl.jump_en_i && !any_hold_w) begin
          redirect_w = 1'b1;
        end else if (ctrl.jump_en_i) begin
          addr_d  = ctrl.jump_addr_i;
          state_d = ST_JUMP_PEND;
        end else if (ctrl.halt_req_i && (flush_cnt_q == 3'd0) && !ctrl.hold_bus_i) begin
          state_d = ST_HALT;
        end
      end
      ST_JUMP_PEND: begin
        redirect_addr_w = addr_q;
        if (!any_hold_w) begin
          redirect_w = 1'b1;
          state_d    = ST_RUN;
        end
      end
      ST_HALT: begin
        if (!ctrl.halt_req_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Flush countdown freezes while the pipeline is held so no bubble is lost.
    if (redirect_w) begin
      flush_cnt_d = FLUSH_INIT;
    end else if (!any_hold_w && (flush_cnt_q != 3'd0)) begin
      flush_cnt_d = flush_cnt_q - 3'd1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end

    if (!ctrl.hold_bus_i) begin
      wdog_d = 16'd0;
    end else if (wdog_q == 16'hFFFF) begin
      wdog_d = wdog_q;
    end else begin
      wdog_d = wdog_q + 16'd1;
    end

    timeout_d = timeout_q | (WDOG_EN && (wdog_d >= TIMEOUT_LIM));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 3'd0;
      addr_q      <= 32'd0;
      wdog_q      <= 16'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      addr_q      <= addr_d;
      wdog_q      <= wdog_d;
      timeout_q   <= timeout_d;
    end
  end

  // Outputs are forced low while reset is asserted.
  assign ctrl.jump_en_o   = !rst && redirect_w;
  assign ctrl.jump_addr_o = (!rst && redirect_w) ? redirect_addr_w : 32'd0;
  assign ctrl.flush_o     = !rst && (redirect_w || (flush_cnt_q != 3'd0));
  assign ctrl.hold_pc_o   = !rst && any_hold_w;
  assign ctrl.hold_if_o   = !rst && any_hold_w;
  assign ctrl.hold_ex_o   = !rst && (ctrl.hold_bus_i || halt_w);
  assign ctrl.halted_o    = !rst && halt_w;
  assign ctrl.timeout_o   = !rst && timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module  : tb_pipe_ctrl
// Brief   : Directed bench for pipe_ctrl with a cycle-level reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;
  localparam int F = 2;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if ifc ();

  pipe_ctrl #(.FLUSH_CYCLES(F), .HOLD_TIMEOUT(T)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (ifc.slave)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: pending redirects as a queue, flush as remaining cycles.
  bit          m_valid = 0;
  bit          m_halted = 0;
  int          m_flush_left = 0;
  logic [31:0] m_pend[$];
  int          m_wdog = 0;
  bit          m_timeout = 0;

  logic        e_hold_any, e_jump;
  logic [31:0] e_addr;
  always_comb begin
    e_hold_any = ifc.hold_ex_i | ifc.hold_bus_i | m_halted;
    e_addr     = (m_pend.size() > 0) ? m_pend[0] : ifc.jump_addr_i;
    e_jump     = !e_hold_any && ((m_pend.size() > 0) || (!m_halted && ifc.jump_en_i));
  end

  bit take_pend, go_halt;
  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1; m_halted = 0; m_flush_left = 0; m_pend.delete();
      m_wdog = 0; m_timeout = 0;
    end else begin
      take_pend = !m_halted && m_pend.size() == 0 && ifc.jump_en_i && e_hold_any;
      go_halt   = !m_halted && m_pend.size() == 0 && !ifc.jump_en_i && ifc.halt_req_i &&
                  m_flush_left == 0 && !ifc.hold_bus_i;
      if (e_jump) begin
        m_pend.delete();
        m_flush_left = F - 1;
      end else if (!e_hold_any && m_flush_left > 0) begin
        m_flush_left--;
      end
      if (take_pend) m_pend.push_back(ifc.jump_addr_i);
      if (m_halted && !ifc.halt_req_i) m_halted = 0;
      else if (go_halt) m_halted = 1;
      m_wdog = ifc.hold_bus_i ? ((m_wdog < 65535) ? m_wdog + 1 : m_wdog) : 0;
      if (T != 0 && m_wdog >= T) m_timeout = 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("jump_en",   {31'd0, ifc.jump_en_o}, {31'd0, !rst && e_jump});
      chk("jump_addr", ifc.jump_addr_o, (!rst && e_jump) ? e_addr : 32'd0);
      chk("flush",     {31'd0, ifc.flush_o}, {31'd0, !rst && (e_jump || m_flush_left > 0)});
      chk("hold_pc",   {31'd0, ifc.hold_pc_o}, {31'd0, !rst && e_hold_any});
      chk("hold_if",   {31'd0, ifc.hold_if_o}, {31'd0, !rst && e_hold_any});
      chk("hold_ex",   {31'd0, ifc.hold_ex_o}, {31'd0, !rst && (ifc.hold_bus_i || m_halted)});
      chk("halted",    {31'd0, ifc.halted_o}, {31'd0, !rst && m_halted});
      chk("timeout",   {31'd0, ifc.timeout_o}, {31'd0, !rst && m_timeout});
    end
  end

  // One clock period: drive just after the rising edge, return at the falling edge.
  task automatic cyc(input bit r, input bit jen, input logic [31:0] a,
                     input bit hex, input bit hbus, input bit halt);
    @(posedge clk); #1;
    rst = r;
    ifc.jump_en_i = jen; ifc.jump_addr_i = a;
    ifc.hold_ex_i = hex; ifc.hold_bus_i = hbus; ifc.halt_req_i = halt;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk({"lit_", name}, act, exp);
  endtask

  task automatic lit_all_zero(input string name);
    lit({name, "_outs"}, {24'd0, ifc.jump_en_o, ifc.flush_o, ifc.hold_pc_o, ifc.hold_if_o,
                          ifc.hold_ex_o, ifc.halted_o, ifc.timeout_o, 1'b0}, 32'd0);
    lit({name, "_addr"}, ifc.jump_addr_o, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    ifc.jump_en_i = 0; ifc.jump_addr_i = 0; ifc.hold_ex_i = 0;
    ifc.hold_bus_i = 0; ifc.halt_req_i = 0;

    cyc(1, 0, 0, 0, 0, 0);
    lit_all_zero("reset");
    cyc(0, 0, 0, 0, 0, 0);
    lit_all_zero("post_reset");

    // Zero-latency redirect, two-cycle flush.
    cyc(0, 1, 32'h100, 0, 0, 0);
    lit("j1_en", {31'd0, ifc.jump_en_o}, 1); lit("j1_addr", ifc.jump_addr_o, 32'h100);
    lit("j1_flush0", {31'd0, ifc.flush_o}, 1);
    cyc(0, 0, 0, 0, 0, 0);
    lit("j1_flush1", {31'd0, ifc.flush_o}, 1); lit("j1_en_off", {31'd0, ifc.jump_en_o}, 0);
    cyc(0, 0, 0, 0, 0, 0);
    lit("j1_flush2", {31'd0, ifc.flush_o}, 0);

    // Redirect deferred behind a 3-cycle bus hold.
    cyc(0, 1, 32'h200, 0, 1, 0);
    lit("j2_noen", {31'd0, ifc.jump_en_o}, 0);
    lit("j2_holds", {29'd0, ifc.hold_pc_o, ifc.hold_if_o, ifc.hold_ex_o}, 32'd7);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    lit("j2_noen3", {31'd0, ifc.jump_en_o}, 0);
    cyc(0, 0, 0, 0, 0, 0);
    lit("j2_en", {31'd0, ifc.jump_en_o}, 1); lit("j2_addr", ifc.jump_addr_o, 32'h200);
    lit("j2_timeout", {31'd0, ifc.timeout_o}, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // EX hold mapping, and flush stretched by an EX hold.
    cyc(0, 0, 0, 1, 0, 0);
    lit("hex_map", {29'd0, ifc.hold_pc_o, ifc.hold_if_o, ifc.hold_ex_o}, 32'd6);
    cyc(0, 1, 32'h300, 0, 0, 0);
    lit("j3_en", {31'd0, ifc.jump_en_o}, 1);
    cyc(0, 0, 0, 1, 0, 0);
    lit("j3_flush_held", {31'd0, ifc.flush_o}, 1);
    cyc(0, 0, 0, 0, 0, 0);
    lit("j3_flush_last", {31'd0, ifc.flush_o}, 1);
    cyc(0, 0, 0, 0, 0, 0);
    lit("j3_flush_done", {31'd0, ifc.flush_o}, 0);

    // Halt request deferred behind a pending jump and its flush.
    cyc(0, 1, 32'h400, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
    lit("h_noen", {31'd0, ifc.jump_en_o}, 0);
    cyc(0, 0, 0, 0, 0, 1);
    lit("h_jump", {31'd0, ifc.jump_en_o}, 1); lit("h_addr", ifc.jump_addr_o, 32'h400);
    lit("h_not_halted0", {31'd0, ifc.halted_o}, 0);
    cyc(0, 0, 0, 0, 0, 1);
    lit("h_flush", {31'd0, ifc.flush_o}, 1); lit("h_not_halted1", {31'd0, ifc.halted_o}, 0);
    cyc(0, 0, 0, 0, 0, 1);
    lit("h_not_halted2", {31'd0, ifc.halted_o}, 0);
    cyc(0, 1, 32'h480, 0, 0, 1);
    lit("h_halted", {31'd0, ifc.halted_o}, 1);
    lit("h_holds", {29'd0, ifc.hold_pc_o, ifc.hold_if_o, ifc.hold_ex_o}, 32'd7);
    lit("h_jump_ignored", {31'd0, ifc.jump_en_o}, 0);
    cyc(0, 0, 0, 0, 0, 0);
    lit("h_still", {31'd0, ifc.halted_o}, 1);
    cyc(0, 0, 0, 0, 0, 0);
    lit("h_released", {31'd0, ifc.halted_o}, 0);
    lit("h_no_late_jump", {31'd0, ifc.jump_en_o}, 0);

    // Watchdog at HOLD_TIMEOUT=4.
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);
    lit("wd_4th", {31'd0, ifc.timeout_o}, 0);
    cyc(0, 0, 0, 0, 0, 0);
    lit("wd_set", {31'd0, ifc.timeout_o}, 1);
    cyc(0, 0, 0, 0, 0, 0);
    lit("wd_sticky", {31'd0, ifc.timeout_o}, 1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    lit("wd_cleared", {31'd0, ifc.timeout_o}, 0);

    // Reset while a redirect is pending.
    cyc(0, 1, 32'h500, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    lit_all_zero("rst_pend");
    cyc(0, 0, 0, 0, 0, 0);
    lit("rst_pend_noen", {31'd0, ifc.jump_en_o}, 0);
    cyc(0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

`default_nettype wire
